// File: rtl/ir_pkg.sv
// Shared IR link definitions: decoder FSM states, carrier timing defaults,
// per-car pulse-count table (shared with the transmitter) and command bit indices.
package ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CARSEL,
        ST_BIT_R,
        ST_BIT_L,
        ST_BIT_B,
        ST_BIT_F
    } ir_state_e;

    // 50 MHz system clock, 36 kHz carrier
    localparam int unsigned DEF_CLK_PER_CARRIER  = 1389;
    localparam int unsigned DEF_BURST_END_CLKS   = 2 * DEF_CLK_PER_CARRIER;
    localparam int unsigned DEF_GAP_TIMEOUT_CLKS = 60 * DEF_CLK_PER_CARRIER;

    localparam int unsigned COUNT_W = 8;
    localparam int unsigned CMD_W   = 4;

    localparam int unsigned CMD_FWD = 3;
    localparam int unsigned CMD_BWD = 2;
    localparam int unsigned CMD_LFT = 1;
    localparam int unsigned CMD_RGT = 0;

    typedef enum logic [1:0] {
        CAR_RED,
        CAR_GREEN,
        CAR_BLUE,
        CAR_YELLOW
    } car_e;

    typedef struct packed {
        logic [COUNT_W-1:0] start_cnt;
        logic [COUNT_W-1:0] carsel_cnt;
        logic [COUNT_W-1:0] gap_cnt;
        logic [COUNT_W-1:0] assert_cnt;
        logic [COUNT_W-1:0] deassert_cnt;
    } car_pulses_t;

    // Burst lengths (in carrier periods) the transmitter uses for each car
    function automatic car_pulses_t car_pulses(input car_e car);
        car_pulses_t p;
        p.start_cnt    = 8'd191;
        p.gap_cnt      = 8'd25;
        p.assert_cnt   = 8'd47;
        p.deassert_cnt = 8'd22;
        case (car)
            CAR_RED:    p.carsel_cnt = 8'd38;
            CAR_GREEN:  p.carsel_cnt = 8'd47;
            CAR_BLUE:   p.carsel_cnt = 8'd54;
            default:    p.carsel_cnt = 8'd60;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ir_burst_detector.sv
// Recovers carrier bursts from the raw IR input: synchroniser, edge detect,
// saturating pulse counter, burst-end detection and post-burst gap timer.
module ir_burst_detector
    import ir_pkg::*;
#(
    parameter int unsigned BURST_END_CLKS   = DEF_BURST_END_CLKS,
    parameter int unsigned GAP_TIMEOUT_CLKS = DEF_GAP_TIMEOUT_CLKS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ir_in,
    output logic               burst_done,
    output logic [COUNT_W-1:0] burst_count,
    output logic               gap_timeout
);

    localparam int unsigned IDLE_W = $clog2(BURST_END_CLKS + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_TIMEOUT_CLKS + 1);

    logic               ir_meta;
    logic               ir_sync;
    logic               ir_prev;
    logic               rise_c;
    logic               in_burst;
    logic [COUNT_W-1:0] pulse_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               gap_run;
    logic [GAP_W-1:0]   gap_cnt;

    assign rise_c = ir_sync & ~ir_prev;

    // idle_cnt holds clocks elapsed since the edge pulse, so it restarts at 1
    // when the edge is consumed; this keeps decode latency at BURST_END_CLKS+4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_meta     <= 1'b0;
            ir_sync     <= 1'b0;
            ir_prev     <= 1'b0;
            in_burst    <= 1'b0;
            pulse_cnt   <= '0;
            idle_cnt    <= '0;
            gap_run     <= 1'b0;
            gap_cnt     <= '0;
            burst_done  <= 1'b0;
            burst_count <= '0;
            gap_timeout <= 1'b0;
        end else begin
            ir_meta     <= ir_in;
            ir_sync     <= ir_meta;
            ir_prev     <= ir_sync;
            burst_done  <= 1'b0;
            gap_timeout <= 1'b0;
            if (rise_c) begin
                in_burst <= 1'b1;
                idle_cnt <= IDLE_W'(1);
                gap_run  <= 1'b0;
                gap_cnt  <= '0;
                if (!in_burst) begin
                    pulse_cnt <= COUNT_W'(1);
                end else if (pulse_cnt != {COUNT_W{1'b1}}) begin
                    pulse_cnt <= pulse_cnt + COUNT_W'(1);
                end
            end else if (in_burst) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
                if (idle_cnt == IDLE_W'(BURST_END_CLKS - 1)) begin
                    burst_done  <= 1'b1;
                    burst_count <= pulse_cnt;
                    in_burst    <= 1'b0;
                    gap_run     <= 1'b1;
                    gap_cnt     <= '0;
                end
            end else if (gap_run) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
                if (gap_cnt == GAP_W'(GAP_TIMEOUT_CLKS - 1)) begin
                    gap_timeout <= 1'b1;
                    gap_run     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ir_packet_decoder.sv
// Decodes an IR burst packet (Start, CarSelect, R, L, B, F) into a 4-bit
// command, flagging malformed or aborted packets.
module ir_packet_decoder
    import ir_pkg::*;
#(
    parameter int unsigned BURST_END_CLKS   = DEF_BURST_END_CLKS,
    parameter int unsigned GAP_TIMEOUT_CLKS = DEF_GAP_TIMEOUT_CLKS,
    parameter int unsigned START_MIN        = 150,
    parameter int unsigned CARSEL_MIN       = 35,
    parameter int unsigned CARSEL_MAX       = 60,
    parameter int unsigned BIT_MIN          = 15,
    parameter int unsigned BIT_MAX          = 60,
    parameter int unsigned ASSERT_MIN       = 35
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ir_in,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    output logic             pkt_error,
    output logic             busy
);

    localparam logic [COUNT_W-1:0] START_MIN_V  = COUNT_W'(START_MIN);
    localparam logic [COUNT_W-1:0] CARSEL_MIN_V = COUNT_W'(CARSEL_MIN);
    localparam logic [COUNT_W-1:0] CARSEL_MAX_V = COUNT_W'(CARSEL_MAX);
    localparam logic [COUNT_W-1:0] BIT_MIN_V    = COUNT_W'(BIT_MIN);
    localparam logic [COUNT_W-1:0] BIT_MAX_V    = COUNT_W'(BIT_MAX);
    localparam logic [COUNT_W-1:0] ASSERT_MIN_V = COUNT_W'(ASSERT_MIN);

    logic               burst_done;
    logic [COUNT_W-1:0] burst_count;
    logic               gap_timeout;

    ir_burst_detector #(
        .BURST_END_CLKS  (BURST_END_CLKS),
        .GAP_TIMEOUT_CLKS(GAP_TIMEOUT_CLKS)
    ) u_burst_detector (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir_in      (ir_in),
        .burst_done (burst_done),
        .burst_count(burst_count),
        .gap_timeout(gap_timeout)
    );

    ir_state_e        state_q, state_d;
    logic [CMD_W-1:0] shadow_q, shadow_d;
    logic             commit_q, commit_d;
    logic [CMD_W-1:0] cmd_d;
    logic             cmd_valid_d;
    logic             pkt_error_d;
    logic             busy_d;
    logic             abort_c;
    logic             is_start_c;
    logic             carsel_ok_c;
    logic             bit_ok_c;
    logic             bit_val_c;

    assign is_start_c  = burst_count >= START_MIN_V;
    assign carsel_ok_c = (burst_count >= CARSEL_MIN_V) && (burst_count <= CARSEL_MAX_V);
    assign bit_ok_c    = (burst_count >= BIT_MIN_V) && (burst_count <= BIT_MAX_V);
    assign bit_val_c   = burst_count >= ASSERT_MIN_V;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            commit_q  <= 1'b0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            pkt_error <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            commit_q  <= commit_d;
            cmd       <= cmd_d;
            cmd_valid <= cmd_valid_d;
            pkt_error <= pkt_error_d;
            busy      <= busy_d;
        end
    end

    // A Start-length burst outside IDLE resyncs to CARSEL instead of aborting.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        commit_d    = 1'b0;
        cmd_d       = cmd;
        cmd_valid_d = 1'b0;
        pkt_error_d = 1'b0;
        busy_d      = busy;
        abort_c     = 1'b0;

        if (commit_q) begin
            cmd_d       = shadow_q;
            cmd_valid_d = 1'b1;
            busy_d      = 1'b0;
        end

        if (burst_done) begin
            if (state_q == ST_IDLE) begin
                if (is_start_c) begin
                    state_d = ST_CARSEL;
                    busy_d  = 1'b1;
                end
            end else if (is_start_c) begin
                pkt_error_d = 1'b1;
                state_d     = ST_CARSEL;
            end else begin
                case (state_q)
                    ST_CARSEL: begin
                        if (carsel_ok_c) state_d = ST_BIT_R;
                        else             abort_c = 1'b1;
                    end
                    ST_BIT_R: begin
                        if (bit_ok_c) begin
                            shadow_d[CMD_RGT] = bit_val_c;
                            state_d           = ST_BIT_L;
                        end else begin
                            abort_c = 1'b1;
                        end
                    end
                    ST_BIT_L: begin
                        if (bit_ok_c) begin
                            shadow_d[CMD_LFT] = bit_val_c;
                            state_d           = ST_BIT_B;
                        end else begin
                            abort_c = 1'b1;
                        end
                    end
                    ST_BIT_B: begin
                        if (bit_ok_c) begin
                            shadow_d[CMD_BWD] = bit_val_c;
                            state_d           = ST_BIT_F;
                        end else begin
                            abort_c = 1'b1;
                        end
                    end
                    ST_BIT_F: begin
                        if (bit_ok_c) begin
                            shadow_d[CMD_FWD] = bit_val_c;
                            state_d           = ST_IDLE;
                            commit_d          = 1'b1;
                        end else begin
                            abort_c = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (gap_timeout && (state_q != ST_IDLE)) begin
            abort_c = 1'b1;
        end

        if (abort_c) begin
            pkt_error_d = 1'b1;
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
        end
    end

endmodule

// File: tb/tb_ir_packet_decoder.sv
// Directed bench for ir_packet_decoder with scaled carrier timing; expected
// strobes are queued as packets are sent and checked by a strobe monitor.
module tb_ir_packet_decoder;

    localparam int unsigned CPC   = 4;
    localparam int unsigned BEND  = 8;
    localparam int unsigned GTO   = 200;
    localparam int unsigned GAP   = 25 * CPC;

    typedef struct {
        logic        err;
        logic [3:0]  cmd;
        int unsigned lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ir_in;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       pkt_error;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_rise = 0;
    logic prev_busy = 1'b0;
    exp_t sb[$];

    ir_packet_decoder #(
        .BURST_END_CLKS  (BEND),
        .GAP_TIMEOUT_CLKS(GTO),
        .START_MIN       (150),
        .CARSEL_MIN      (35),
        .CARSEL_MAX      (60),
        .BIT_MIN         (15),
        .BIT_MAX         (60),
        .ASSERT_MIN      (35)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ir_in    (ir_in),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .pkt_error(pkt_error),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (cmd_valid !== 1'b0 || pkt_error !== 1'b0)) begin
            chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
            chk("strobe_exclusive", 32'(cmd_valid & pkt_error), 32'd0);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_kind", 32'(pkt_error), 32'(e.err));
                chk("strobe_cmd", 32'(cmd), 32'(e.cmd));
                chk("strobe_latency", 32'(cyc - last_rise), 32'(e.lat));
                if (!e.err) begin
                    chk("busy_fall_with_valid", 32'({prev_busy, busy}), 32'b10);
                end
            end
        end
        prev_busy <= busy;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            ir_in     = 1'b1;
            last_rise = cyc;
            idle(CPC / 2);
            ir_in = 1'b0;
            idle(CPC / 2);
        end
        idle(GAP);
    endtask

    task automatic push(input logic err, input logic [3:0] c, input int unsigned lat);
        exp_t e;
        e.err = err;
        e.cmd = c;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic packet(input int s, input int c, input int r, input int l,
                          input int b, input int f);
        burst(s); burst(c); burst(r); burst(l); burst(b); burst(f);
    endtask

    initial begin
        rst_n = 1'b0;
        ir_in = 1'b0;
        idle(3);
        chk("reset_cmd", 32'(cmd), 32'd0);
        chk("reset_valid", 32'(cmd_valid), 32'd0);
        chk("reset_error", 32'(pkt_error), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Good packet -> 1010, checking BUSY mid-packet
        push(1'b0, 4'b1010, BEND + 4);
        burst(191);
        chk("busy_after_start", 32'(busy), 32'd1);
        burst(47); burst(22); burst(47); burst(22); burst(47);
        chk("good_cmd", 32'(cmd), 32'hA);
        chk("good_busy_low", 32'(busy), 32'd0);

        // All-zero packet
        push(1'b0, 4'b0000, BEND + 4);
        packet(191, 47, 22, 22, 22, 22);
        chk("zero_cmd", 32'(cmd), 32'h0);

        // Noise in IDLE: no strobes, no BUSY
        burst(5);
        chk("noise5_busy", 32'(busy), 32'd0);
        burst(40);
        idle(GTO + 20);
        chk("noise40_busy", 32'(busy), 32'd0);
        chk("noise_cmd", 32'(cmd), 32'h0);

        // 0101 then a bad L bit (80 pulses), then a good packet
        push(1'b0, 4'b0101, BEND + 4);
        packet(191, 60, 47, 22, 47, 15);
        chk("cmd_0101", 32'(cmd), 32'h5);
        push(1'b1, 4'b0101, BEND + 3);
        burst(191); burst(47); burst(22); burst(80);
        chk("badbit_busy", 32'(busy), 32'd0);
        chk("badbit_cmd", 32'(cmd), 32'h5);
        push(1'b0, 4'b1010, BEND + 4);
        packet(191, 35, 34, 35, 14 + 1, 60);
        chk("after_bad_cmd", 32'(cmd), 32'hA);

        // Gap timeout after the B burst
        push(1'b1, 4'b1010, GTO + BEND + 3);
        burst(191); burst(47); burst(47); burst(47); burst(47);
        idle(300);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_cmd", 32'(cmd), 32'hA);

        // Resync: Start burst while in BIT_L
        push(1'b1, 4'b1010, BEND + 3);
        push(1'b0, 4'b0011, BEND + 4);
        burst(191); burst(47); burst(22); burst(255);
        chk("resync_busy", 32'(busy), 32'd1);
        burst(47); burst(47); burst(47); burst(22); burst(22);
        chk("resync_cmd", 32'(cmd), 32'h3);

        // Asynchronous reset during the B burst
        burst(191); burst(47); burst(47); burst(22);
        for (int i = 0; i < 10; i++) begin
            ir_in = 1'b1; idle(2); ir_in = 1'b0; idle(2);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_cmd", 32'(cmd), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_strobes", 32'({cmd_valid, pkt_error}), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(GTO + 20);
        chk("post_arst_busy", 32'(busy), 32'd0);
        push(1'b0, 4'b1010, BEND + 4);
        packet(191, 47, 22, 47, 22, 47);
        chk("post_arst_cmd", 32'(cmd), 32'hA);

        idle(20);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_packet_decoder.md
Name: ir_packet_decoder

Overview:
- Receive-side stage directly downstream of the IR transmitter's IR_LED output. Consumes the carrier-modulated burst packet (Start, CarSelect, Right, Left, Backward, Forward, each burst followed by a gap) and recovers the 4 direction bits.
- Used as an on-board loopback checker and as a bench reference decoder for the transmitter.
- Flags malformed packets.

Parameters:
- CLK_PER_CARRIER, 1389: system clocks per carrier period (50 MHz / 36 kHz).
- BURST_END_CLKS, 2778: clocks with no carrier rising edge that close a burst (2 carrier periods).
- GAP_TIMEOUT_CLKS, 83340: clocks of silence after a burst that abort a packet (60 carrier periods).
- START_MIN, 150: minimum pulses for a Start burst.
- CARSEL_MIN, 35: minimum pulses for a CarSelect burst.
- CARSEL_MAX, 60: maximum pulses for a CarSelect burst.
- BIT_MIN, 15: minimum pulses for a valid direction burst. Shorter bursts are noise or error.
- BIT_MAX, 60: maximum pulses for a valid direction burst.
- ASSERT_MIN, 35: direction burst pulse count at or above this value decodes as 1. Below it decodes as 0.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  asynchronous, active-low reset.
- IR_IN  in  1  modulated IR input, asynchronous to CLK.
- CMD  out  4  last good command: {FORWARD, BACKWARD, LEFT, RIGHT}.
- CMD_VALID  out  1  one-cycle strobe when CMD updates.
- PKT_ERROR  out  1  one-cycle strobe on a malformed or aborted packet.
- BUSY  out  1  high from Start-burst acceptance until packet end or abort.

Behaviour:
- Reset (RST low, asynchronous):
  - All state returns to IDLE.
  - CMD=0, CMD_VALID=0, PKT_ERROR=0, BUSY=0.
  - All counters clear.
  - Reset mid-packet discards the partial packet with no strobe.
- Input path:
  - 2-FF synchroniser on IR_IN, then rising-edge detect.
  - Edge-to-count latency is 3 clocks.
- Pulse counter:
  - 8 bits, counts rising edges within the current burst.
  - Saturates at 255; no wrap.
- Burst end:
  - Fires when the idle counter reaches BURST_END_CLKS since the last edge.
  - Produces a one-cycle burst_done with the count latched.
  - The idle counter is reset by every edge.
- Gap timer:
  - Starts at burst_done and clears on the next edge.
  - Reaching GAP_TIMEOUT_CLKS while BUSY means abort: PKT_ERROR pulses, state returns to IDLE.
  - In IDLE the gap timer is ignored.
- FSM states: IDLE, CARSEL, BIT_R, BIT_L, BIT_B, BIT_F.
  - IDLE: burst_done with count>=START_MIN goes to CARSEL and sets BUSY. Any other burst is ignored (noise, no error).
  - CARSEL: count in [CARSEL_MIN, CARSEL_MAX] goes to BIT_R.
  - BIT_x: count in [BIT_MIN, BIT_MAX] stores bit x = (count>=ASSERT_MIN) and advances R, L, B, F in that order.
  - Out-of-range count in CARSEL or BIT_x: PKT_ERROR, then IDLE.
  - Exception: count>=START_MIN in any non-IDLE state pulses PKT_ERROR and goes directly to CARSEL. This is a resync; BUSY stays high.
  - BIT_F accepted: on the next clock CMD takes the 4 shadow bits, CMD_VALID pulses, BUSY falls, state returns to IDLE.
- CMD holds its value until the next good packet. Errors never alter CMD.
- Latency: CMD_VALID asserts BURST_END_CLKS+4 clocks after the last Forward-burst edge at IR_IN.
- CMD_VALID and PKT_ERROR are never high in the same cycle.

Decomposition:
- Shared package ir_pkg:
  - FSM state enum.
  - Per-car pulse-count constants (start, carsel, gap, assert, deassert for each car colour), shared with the transmitter.
  - Default carrier timing constants.
  - CMD bit index constants (FWD=3, BWD=2, LFT=1, RGT=0).
- One sub-module, ir_burst_detector:
  - Contains the synchroniser, edge detect, saturating pulse counter, burst-end idle counter and gap timer.
  - Outputs burst_done, burst_count[7:0] and gap_timeout.
- The top-level module contains the FSM and output registers only.

Test Plan:
- All benches use scaled parameters: CLK_PER_CARRIER=4, BURST_END_CLKS=8, GAP_TIMEOUT_CLKS=200, START_MIN=150, CARSEL 35..60, BIT 15..60, ASSERT_MIN=35.
- Good packet: Start 191, CarSel 47, R=22, L=47, B=22, F=47 pulses, 25-period gaps -> single CMD_VALID, CMD=4'b1010, no PKT_ERROR, BUSY falls the same cycle CMD_VALID rises.
- All-zero packet: bits all 22 pulses after a prior CMD=1010 -> CMD=4'b0000, CMD_VALID once.
- Noise in IDLE: 5-pulse burst, then 40-pulse burst -> no strobes, BUSY=0, CMD unchanged.
- Bad bit: L burst of 80 pulses -> PKT_ERROR one cycle, BUSY=0, CMD unchanged, next good packet decodes correctly.
- Gap timeout: stop after the B burst for 300 clocks -> PKT_ERROR at gap 200, state IDLE; resync case: Start burst during BIT_L -> PKT_ERROR, BUSY stays 1, following CarSel+4 bits decode.
- Reset mid-packet: RST low for 3 clocks during BIT_B -> all outputs 0 immediately (async), no strobes, subsequent good packet decodes.
